// File: rtl/exe_unit_pkg.sv
// rtl/exe_unit_pkg.sv - shared constants, FSM state type and LFSR step for the exe_unit self-test engine
package exe_unit_pkg;

    localparam int M_DEF = 9;
    localparam int N_DEF = 4;

    localparam int VF = 0;
    localparam int PF = 1;
    localparam int NF = 2;
    localparam int OF = 3;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_t;

    // Right-shifting Galois step: feedback taps are applied when bit 0 falls out
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/exe_unit_lfsr.sv
// rtl/exe_unit_lfsr.sv - 32-bit Galois LFSR with synchronous load and advance enable
module exe_unit_lfsr
    import exe_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= load_val;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/exe_unit_bist.sv
// rtl/exe_unit_bist.sv - dual exe_unit compare engine; EXE_BIST_FIRST_ERR_EN adds first-mismatch capture
module exe_unit_bist
    import exe_unit_pkg::*;
#(
    parameter int          M       = M_DEF,
    parameter int          N       = N_DEF,
    parameter int          NUM_VEC = 10000,
    parameter int          LAT     = 0,
    parameter logic [31:0] SEED    = 32'h1,
    parameter int          CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic [M-1:0]     o_argA,
    output logic [M-1:0]     o_argB,
    output logic [N-1:0]     o_oper,
    input  logic [M-1:0]     i_result_a,
    input  logic [3:0]       i_flags_a,
    input  logic [M-1:0]     i_result_b,
    input  logic [3:0]       i_flags_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_res_cnt,
    output logic [CNT_W-1:0] o_err_flag_cnt,
    output logic [CNT_W-1:0] o_ok_cnt
`ifdef EXE_BIST_FIRST_ERR_EN
    ,
    output logic             o_ferr_valid,
    output logic [CNT_W-1:0] o_ferr_idx,
    output logic [N-1:0]     o_ferr_oper,
    output logic [M-1:0]     o_ferr_argA,
    output logic [M-1:0]     o_ferr_argB
`endif
);

    localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int               VW       = $clog2(NUM_VEC + 1);
    localparam logic [VW-1:0]    LAST_IDX = VW'(NUM_VEC - 1);
    localparam logic [VW-1:0]    V_ONE    = 1;
    localparam logic [N-1:0]     OP_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    generate
        if (2 * M > 32) begin : g_width_check
            $error("exe_unit_bist: 2*M must not exceed 32");
        end
    endgenerate

    bist_state_t  fsm_state;
    logic [31:0]  lfsr_state;
    logic         shown;
    logic [VW-1:0] issue_cnt;
    logic [VW-1:0] cmp_cnt;
    logic         start_ok;
    logic         issue;
    logic         issue_last;
    logic         cmp_valid;
    logic         cmp_last;
    logic         res_mis;
    logic         flag_mis;

    assign start_ok   = i_start && ((fsm_state == IDLE) || (fsm_state == DONE));
    assign issue      = (fsm_state == RUN);
    assign issue_last = issue && (issue_cnt == LAST_IDX);
    assign cmp_last   = cmp_valid && (cmp_cnt == LAST_IDX);
    assign res_mis    = (i_result_a != i_result_b);
    assign flag_mis   = (i_flags_a != i_flags_b);

    // The LFSR stops on the last vector so the stimulus holds through DRAIN and DONE
    exe_unit_lfsr #(
        .RESET_VAL (SEED_EFF)
    ) u_lfsr (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (start_ok),
        .load_val (SEED_EFF),
        .advance  (issue && !issue_last),
        .state    (lfsr_state)
    );

    assign o_argA = shown ? lfsr_state[M-1:0]   : '0;
    assign o_argB = shown ? lfsr_state[2*M-1:M] : '0;

    generate
        if (2 * M < 32) begin : g_lfsr_spare
            logic unused_lfsr;
            assign unused_lfsr = ^lfsr_state[31:2*M];
        end
    endgenerate

    generate
        if (LAT == 0) begin : g_no_lat
            assign cmp_valid = issue;
        end else begin : g_lat
            logic [LAT-1:0] vld_pipe;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe <= (vld_pipe << 1) | LAT'(issue);
                end
            end
            assign cmp_valid = vld_pipe[LAT-1];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_state      <= IDLE;
            shown          <= 1'b0;
            o_oper         <= '0;
            issue_cnt      <= '0;
            cmp_cnt        <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_pass         <= 1'b0;
            o_err_res_cnt  <= '0;
            o_err_flag_cnt <= '0;
            o_ok_cnt       <= '0;
        end else begin
            case (fsm_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        fsm_state      <= RUN;
                        shown          <= 1'b1;
                        o_oper         <= OP_ONE;
                        issue_cnt      <= '0;
                        cmp_cnt        <= '0;
                        o_busy         <= 1'b1;
                        o_done         <= 1'b0;
                        o_pass         <= 1'b0;
                        o_err_res_cnt  <= '0;
                        o_err_flag_cnt <= '0;
                        o_ok_cnt       <= '0;
                    end
                end
                RUN: begin
                    if (!issue_last) begin
                        issue_cnt <= issue_cnt + V_ONE;
                        o_oper    <= o_oper + OP_ONE;
                    end else if (LAT != 0) begin
                        fsm_state <= DRAIN;
                    end
                end
                default: ;
            endcase

            // Compare slots never coincide with a start, so the clears above cannot collide
            if (cmp_valid) begin
                cmp_cnt <= cmp_cnt + V_ONE;
                if (res_mis && (o_err_res_cnt != CNT_MAX)) begin
                    o_err_res_cnt <= o_err_res_cnt + CNT_ONE;
                end
                if (flag_mis && (o_err_flag_cnt != CNT_MAX)) begin
                    o_err_flag_cnt <= o_err_flag_cnt + CNT_ONE;
                end
                if (!res_mis && !flag_mis && (o_ok_cnt != CNT_MAX)) begin
                    o_ok_cnt <= o_ok_cnt + CNT_ONE;
                end
                if (cmp_last) begin
                    fsm_state <= DONE;
                    o_busy    <= 1'b0;
                    o_done    <= 1'b1;
                    o_pass    <= (o_err_res_cnt == '0) && !res_mis &&
                                 (o_err_flag_cnt == '0) && !flag_mis;
                end
            end
        end
    end

`ifdef EXE_BIST_FIRST_ERR_EN
    localparam int SW = N + 2 * M;

    logic [SW-1:0] cmp_stim;

    generate
        if (LAT == 0) begin : g_stim_now
            assign cmp_stim = {o_oper, o_argA, o_argB};
        end else begin : g_stim_pipe
            logic [SW-1:0] stim_pipe [LAT];
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        stim_pipe[i] <= '0;
                    end
                end else begin
                    stim_pipe[0] <= {o_oper, o_argA, o_argB};
                    for (int i = 1; i < LAT; i++) begin
                        stim_pipe[i] <= stim_pipe[i-1];
                    end
                end
            end
            assign cmp_stim = stim_pipe[LAT-1];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ferr_valid <= 1'b0;
            o_ferr_idx   <= '0;
            o_ferr_oper  <= '0;
            o_ferr_argA  <= '0;
            o_ferr_argB  <= '0;
        end else if (start_ok) begin
            o_ferr_valid <= 1'b0;
            o_ferr_idx   <= '0;
            o_ferr_oper  <= '0;
            o_ferr_argA  <= '0;
            o_ferr_argB  <= '0;
        end else if (cmp_valid && (res_mis || flag_mis) && !o_ferr_valid) begin
            o_ferr_valid <= 1'b1;
            o_ferr_idx   <= CNT_W'(cmp_cnt) + CNT_ONE;
            {o_ferr_oper, o_ferr_argA, o_ferr_argB} <= cmp_stim;
        end
    end
`endif

endmodule
